// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding, baud divider rounding.
// Latency: n/a (types, constants and an elaboration-time function only).
// Backpressure: n/a.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } rx_state_t;

    // Rounded clocks-per-oversample-tick. Scaled by 10 so the rounding stays in
    // integer arithmetic; 64-bit so fast system clocks do not overflow.
    function automatic int baud_div(input longint sys_clock,
                                    input longint baudrate,
                                    input longint oversample);
        longint div_x10;
        div_x10 = (sys_clock * 64'sd10) / (baudrate * oversample);
        return int'((div_x10 + 64'sd5) / 64'sd10);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock o_Tick every DIV clocks while enabled.
// Latency: first tick DIV clocks after i_Enable rises; counter held at 0 while disabled.
// Backpressure: none; free-running while enabled.
// Ports: i_SysClock/i_ResetN clock and async active-low reset, i_Enable run/clear,
//        o_Tick single-cycle strobe on counter wrap.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int SYS_CLOCK     = 50000000,
    parameter int UART_BAUDRATE = 115200,
    parameter int OVERSAMPLE    = 16
) (
    input  logic i_SysClock,
    input  logic i_ResetN,
    input  logic i_Enable,
    output logic o_Tick
);

    localparam int DIV   = baud_div(longint'(SYS_CLOCK), longint'(UART_BAUDRATE),
                                    longint'(OVERSAMPLE));
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_Count;
    logic             w_Wrap;

    assign w_Wrap = (r_Count == CNT_LAST);

    // Clearing while disabled lets the owner align the tick phase to an event
    // (the receiver uses the start-bit edge).
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            r_Count <= '0;
        end else if (!i_Enable || w_Wrap) begin
            r_Count <= '0;
        end else begin
            r_Count <= r_Count + 1'b1;
        end
    end

    assign o_Tick = i_Enable && w_Wrap;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5-9 data bits, none/even/odd parity, 1-2 stop bits), 3-sample majority.
// Latency: o_RxValid rises one clock after the majority sample of the last stop bit.
// Backpressure: one-word holding register; a frame completing while the word is unaccepted is dropped with o_Overrun.
// Ports: i_SysClock, i_ResetN (async active-low), i_RxSerial (async line, idle high),
//        o_RxData/o_RxValid/i_RxReady (word handshake), o_ParityErr/o_FrameErr (per held word),
//        o_Overrun/o_Break (single-cycle pulses), o_Busy (receiver not idle).
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int SYS_CLOCK     = 50000000,
    parameter int UART_BAUDRATE = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int OVERSAMPLE    = 16
) (
    input  logic                 i_SysClock,
    input  logic                 i_ResetN,
    input  logic                 i_RxSerial,
    output logic [DATA_BITS-1:0] o_RxData,
    output logic                 o_RxValid,
    input  logic                 i_RxReady,
    output logic                 o_ParityErr,
    output logic                 o_FrameErr,
    output logic                 o_Overrun,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int SCW  = $clog2(OVERSAMPLE);
    localparam int HALF = OVERSAMPLE / 2;
    localparam logic [SCW-1:0] CNT_S0   = SCW'(HALF - 1);
    localparam logic [SCW-1:0] CNT_S1   = SCW'(HALF);
    localparam logic [SCW-1:0] CNT_MAJ  = SCW'(HALF + 1);
    localparam logic [SCW-1:0] CNT_END  = SCW'(OVERSAMPLE - 1);
    localparam logic [3:0]     LAST_DAT = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STP = 4'(STOP_BITS - 1);

    logic                 r_Sync1, r_Sync2, w_Rx;
    rx_state_t            r_State, w_NextState;
    logic                 w_TickEn, w_Tick, w_Busy;
    logic [SCW-1:0]       r_SampleCnt;
    logic                 r_S0, r_S1;
    logic                 w_Maj, w_MajPoint, w_BitEnd;
    logic [3:0]           r_BitCnt;
    logic [DATA_BITS-1:0] r_Shift;
    logic                 r_ParBit, r_StopErr;
    logic                 w_LastStop, w_FirstStopLow, w_IsBreak;
    logic                 w_Complete, w_BreakEntry, w_ParityErr, w_FrameErr;
    logic [DATA_BITS-1:0] r_RxData;
    logic                 r_RxValid, r_ParityErr, r_FrameErr, r_Overrun, r_Break;

    // Two-flop synchroniser, reset to the idle (high) line level.
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            r_Sync1 <= 1'b1;
            r_Sync2 <= 1'b1;
        end else begin
            r_Sync1 <= i_RxSerial;
            r_Sync2 <= r_Sync1;
        end
    end
    assign w_Rx = r_Sync2;

    uart_baud_tick #(
        .SYS_CLOCK    (SYS_CLOCK),
        .UART_BAUDRATE(UART_BAUDRATE),
        .OVERSAMPLE   (OVERSAMPLE)
    ) u_tick (
        .i_SysClock(i_SysClock),
        .i_ResetN  (i_ResetN),
        .i_Enable  (w_TickEn),
        .o_Tick    (w_Tick)
    );

    // The third vote is the live sample at the majority point.
    assign w_MajPoint = w_Tick && (r_SampleCnt == CNT_MAJ);
    assign w_BitEnd   = w_Tick && (r_SampleCnt == CNT_END);
    assign w_Maj      = (r_S0 & r_S1) | (r_S0 & w_Rx) | (r_S1 & w_Rx);

    // Finishing at the last stop bit's majority point leaves half a bit of
    // slack for a back-to-back start edge.
    assign w_LastStop     = (r_State == ST_STOP) && w_MajPoint && (r_BitCnt == LAST_STP);
    // With two stop bits the first one has already been folded into r_StopErr.
    assign w_FirstStopLow = (STOP_BITS == 1) ? !w_Maj : r_StopErr;
    assign w_IsBreak      = (r_Shift == '0) && ((PARITY == PAR_NONE) || !r_ParBit) && w_FirstStopLow;
    assign w_Complete     = w_LastStop && !w_IsBreak;
    assign w_BreakEntry   = w_LastStop && w_IsBreak;
    assign w_ParityErr    = (PARITY != PAR_NONE) &&
                            (r_ParBit != ((^r_Shift) ^ (PARITY == PAR_ODD)));
    assign w_FrameErr     = r_StopErr | !w_Maj;

    // FSM: state register
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            r_State <= ST_IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    // FSM: next state
    always_comb begin
        w_NextState = r_State;
        unique case (r_State)
            ST_IDLE: begin
                if (!w_Rx) w_NextState = ST_START;
            end
            ST_START: begin
                if (w_MajPoint && w_Maj) w_NextState = ST_IDLE;   // false start
                else if (w_BitEnd)       w_NextState = ST_DATA;
            end
            ST_DATA: begin
                if (w_BitEnd && (r_BitCnt == LAST_DAT))
                    w_NextState = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_BitEnd) w_NextState = ST_STOP;
            end
            ST_STOP: begin
                if (w_LastStop) w_NextState = w_IsBreak ? ST_BREAK_WAIT : ST_IDLE;
            end
            ST_BREAK_WAIT: begin
                if (w_Rx) w_NextState = ST_IDLE;
            end
            default: w_NextState = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_Busy   = (r_State != ST_IDLE);
        w_TickEn = w_Busy;
    end

    // Oversample position within the current bit and the two stored votes.
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            r_SampleCnt <= '0;
            r_S0        <= 1'b1;
            r_S1        <= 1'b1;
        end else begin
            if (r_State == ST_IDLE)
                r_SampleCnt <= '0;
            else if (w_Tick)
                r_SampleCnt <= (r_SampleCnt == CNT_END) ? '0 : r_SampleCnt + 1'b1;
            if (w_Tick && (r_SampleCnt == CNT_S0)) r_S0 <= w_Rx;
            if (w_Tick && (r_SampleCnt == CNT_S1)) r_S1 <= w_Rx;
        end
    end

    // Bit index within DATA / STOP; restarts on every state change.
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            r_BitCnt <= '0;
        end else if (r_State != w_NextState) begin
            r_BitCnt <= '0;
        end else if (w_BitEnd) begin
            r_BitCnt <= r_BitCnt + 1'b1;
        end
    end

    // Frame contents: LSB-first shift, parity bit, sticky stop-bit error.
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            r_Shift   <= '0;
            r_ParBit  <= 1'b0;
            r_StopErr <= 1'b0;
        end else begin
            if (r_State == ST_IDLE)
                r_StopErr <= 1'b0;
            if ((r_State == ST_DATA) && w_MajPoint)
                r_Shift <= {w_Maj, r_Shift[DATA_BITS-1:1]};
            if ((r_State == ST_PARITY) && w_MajPoint)
                r_ParBit <= w_Maj;
            if ((r_State == ST_STOP) && w_MajPoint && !w_Maj)
                r_StopErr <= 1'b1;
        end
    end

    // Holding register. A same-cycle accept frees the slot for the new word.
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            r_RxData    <= '0;
            r_RxValid   <= 1'b0;
            r_ParityErr <= 1'b0;
            r_FrameErr  <= 1'b0;
            r_Overrun   <= 1'b0;
            r_Break     <= 1'b0;
        end else begin
            r_Overrun <= w_Complete && r_RxValid && !i_RxReady;
            r_Break   <= w_BreakEntry;
            if (w_Complete && (!r_RxValid || i_RxReady)) begin
                r_RxData    <= r_Shift;
                r_ParityErr <= w_ParityErr;
                r_FrameErr  <= w_FrameErr;
                r_RxValid   <= 1'b1;
            end else if (r_RxValid && i_RxReady) begin
                r_RxValid <= 1'b0;
            end
        end
    end

    assign o_RxData    = r_RxData;
    assign o_RxValid   = r_RxValid;
    assign o_ParityErr = r_ParityErr;
    assign o_FrameErr  = r_FrameErr;
    assign o_Overrun   = r_Overrun;
    assign o_Break     = r_Break;
    assign o_Busy      = w_Busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: instance 0 is 8N1, instance 1 is 8E1.
// Frames are driven bit by bit; a frame-level model predicts words, flags, overrun and break counts.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int OS   = 16;
    localparam int DIV  = ((50000000 * 10 / (115200 * OS)) + 5) / 10;
    localparam int BITT = DIV * OS;
    localparam int HALF = OS / 2;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0]      line, ready, valid, perr, ferr, ovr, brk, busy;
    logic [1:0][7:0] data;

    exp_t       exp_q [2][$];
    int         ovr_exp [2], brk_exp [2], ovr_seen [2], brk_seen [2], acc_cnt [2];
    logic [7:0] last_d [2];
    logic       last_pe [2], last_fe [2];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int NB = (g == 1) ? 10 : 9;   // bits preceding the stop bit
        logic pv = 1'b0;

        uart_rx_cfg #(
            .SYS_CLOCK    (50000000),
            .UART_BAUDRATE(115200),
            .DATA_BITS    (8),
            .PARITY       ((g == 1) ? 1 : 0),
            .STOP_BITS    (1),
            .OVERSAMPLE   (OS)
        ) u_dut (
            .i_SysClock (clk),
            .i_ResetN   (rst_n),
            .i_RxSerial (line[g]),
            .o_RxData   (data[g]),
            .o_RxValid  (valid[g]),
            .i_RxReady  (ready[g]),
            .o_ParityErr(perr[g]),
            .o_FrameErr (ferr[g]),
            .o_Overrun  (ovr[g]),
            .o_Break    (brk[g]),
            .o_Busy     (busy[g])
        );

        always @(negedge clk) begin
            exp_t e;
            int   lat;
            if (rst_n) begin
                if (valid[g]) begin
                    total++;
                    if (exp_q[g].size() == 0) begin
                        bad++;
                        $display("FAIL spurious_word inst%0d: got data=%h, required no word", g, data[g]);
                    end else begin
                        e = exp_q[g][0];
                        if (data[g] !== e.d || perr[g] !== e.pe || ferr[g] !== e.fe) begin
                            bad++;
                            $display("FAIL word inst%0d: got d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b",
                                     g, data[g], perr[g], ferr[g], e.d, e.pe, e.fe);
                        end
                        if (!pv) begin
                            lat = cyc - e.t0;
                            total++;
                            if (lat < (NB * OS + HALF + 1) * DIV || lat > (NB * OS + HALF + 2) * DIV + 6) begin
                                bad++;
                                $display("FAIL valid_latency inst%0d: got %0d clocks, required %0d..%0d",
                                         g, lat, (NB * OS + HALF + 1) * DIV, (NB * OS + HALF + 2) * DIV + 6);
                            end
                        end
                        if (ready[g]) begin
                            last_d[g]  = data[g];
                            last_pe[g] = perr[g];
                            last_fe[g] = ferr[g];
                            acc_cnt[g]++;
                            void'(exp_q[g].pop_front());
                        end
                    end
                end
                if (ovr[g]) ovr_seen[g]++;
                if (brk[g]) brk_seen[g]++;
            end
            pv = valid[g] && rst_n;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Frame-level expectation: break, dropped (overrun) or a delivered word.
    function automatic void model_frame(input int g, input logic [7:0] d, input logic pbit, input logic stopv);
        exp_t e;
        logic par_on;
        par_on = (g == 1);
        e.d  = d;
        e.pe = par_on && (pbit != (^d));
        e.fe = !stopv;
        e.t0 = cyc;
        if (d == 8'h00 && (!par_on || !pbit) && !stopv) brk_exp[g]++;
        else if (exp_q[g].size() != 0 && !ready[g])    ovr_exp[g]++;
        else                                            exp_q[g].push_back(e);
    endfunction

    task automatic send(input int g, input logic [7:0] d, input logic pbit, input logic stopv);
        model_frame(g, d, pbit, stopv);
        line[g] = 1'b0;
        wait_cyc(BITT);
        for (int i = 0; i < 8; i++) begin
            line[g] = d[i];
            wait_cyc(BITT);
        end
        if (g == 1) begin
            line[g] = pbit;
            wait_cyc(BITT);
        end
        line[g] = stopv;
        wait_cyc(BITT);
        line[g] = 1'b1;
        wait_cyc(BITT / 2);
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        bad++;
        $display("FAIL watchdog: cycle budget expired at %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        line  = 2'b11;
        ready = 2'b11;
        rst_n = 1'b0;
        wait_cyc(5);
        check("reset_outputs", {data, valid, perr, ferr, ovr, brk, busy}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(5);

        // 1: clean 8N1 word
        send(0, 8'hA5, 1'b0, 1'b1);
        check("t1_data", last_d[0], 8'hA5);
        check("t1_flags", {last_pe[0], last_fe[0]}, 2'b00);
        check("t1_accepts", acc_cnt[0], 1);

        // 2: even parity, wrong then right parity bit
        send(1, 8'h03, 1'b1, 1'b1);
        check("t2_data", last_d[1], 8'h03);
        check("t2_perr_bad", last_pe[1], 1'b1);
        send(1, 8'h03, 1'b0, 1'b1);
        check("t2_perr_good", last_pe[1], 1'b0);

        // 3: framing error then clean word
        send(0, 8'h55, 1'b0, 1'b0);
        check("t3_data", last_d[0], 8'h55);
        check("t3_ferr", last_fe[0], 1'b1);
        send(0, 8'h0F, 1'b0, 1'b1);
        check("t3_next_data", last_d[0], 8'h0F);
        check("t3_next_ferr", last_fe[0], 1'b0);

        // 4: short low glitch is a false start
        line[0] = 1'b0;
        wait_cyc(100);
        line[0] = 1'b1;
        check("t4_busy_on_glitch", busy[0], 1'b1);
        n = 0;
        while (busy[0] && n < BITT) begin
            wait_cyc(1);
            n++;
        end
        check("t4_busy_cleared", busy[0], 1'b0);
        send(0, 8'h3C, 1'b0, 1'b1);
        check("t4_data", last_d[0], 8'h3C);
        check("t4_accepts", acc_cnt[0], 4);

        // 5: overrun while the consumer stalls
        ready[0] = 1'b0;
        send(0, 8'h11, 1'b0, 1'b1);
        send(0, 8'h22, 1'b0, 1'b1);
        check("t5_held_data", data[0], 8'h11);
        check("t5_held_valid", valid[0], 1'b1);
        check("t5_overrun_pulses", ovr_seen[0], 1);
        ready[0] = 1'b1;
        wait_cyc(3);
        check("t5_valid_dropped", valid[0], 1'b0);
        check("t5_accepted", last_d[0], 8'h11);

        // 6: break, then reset in the middle of a frame
        model_frame(0, 8'h00, 1'b0, 1'b0);
        line[0] = 1'b0;
        wait_cyc(12 * BITT);
        line[0] = 1'b1;
        wait_cyc(BITT / 2);
        check("t6_break_pulses", brk_seen[0], 1);
        check("t6_idle_after_break", busy[0], 1'b0);

        ready[1] = 1'b0;
        send(1, 8'h5A, 1'b0, 1'b1);
        line[0] = 1'b0;                       // start of 0x7E
        wait_cyc(BITT);
        line[0] = 1'b0; wait_cyc(BITT);
        line[0] = 1'b1; wait_cyc(BITT);
        line[0] = 1'b1; wait_cyc(BITT / 2);
        check("t6_pre_reset_state", {busy[0], valid[1]}, 2'b11);
        #7;
        rst_n = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        #1;
        check("t6_reset_outputs", {data, valid, perr, ferr, ovr, brk, busy}, 32'h0);
        wait_cyc(3);
        line[0]  = 1'b1;
        ready[1] = 1'b1;
        rst_n    = 1'b1;
        wait_cyc(5);
        send(0, 8'h81, 1'b0, 1'b1);
        check("t6_after_reset", last_d[0], 8'h81);

        // Random frames on both formats
        for (int k = 0; k < 4; k++) begin
            send(k % 2, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0));
        end

        wait_cyc(10);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("end_queue_empty_%0d", g), exp_q[g].size(), 0);
            check($sformatf("end_overrun_%0d", g), ovr_seen[g], ovr_exp[g]);
            check($sformatf("end_break_%0d", g), brk_seen[g], brk_exp[g]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
